// File: rtl/config_pkg.sv
// Shared definitions for the serial configuration loader: state encodings
// and the default width of the connection-block select bus.
package config_pkg;

  localparam int CFG_WIDTH_DEFAULT = 88;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_COMMIT = 2'b10,
    ST_DONE   = 2'b11
  } cfg_state_e;

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow shift register for the configuration bitstream. Each accepted bit
// enters at bit 0 while the displaced MSB is forwarded down the daisy chain.
module cfg_shift_reg #(
  parameter int WIDTH = 88
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] shadow,
  output logic             cfg_out,
  output logic             cfg_out_valid
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             cfg_out_q, cfg_out_d;
  logic             cfg_out_valid_q, cfg_out_valid_d;

  // Next-state for the shadow word and the forwarded chain bit.
  always_comb begin
    shadow_d        = shadow_q;
    cfg_out_d       = cfg_out_q;
    cfg_out_valid_d = 1'b0;
    if (shift_en) begin
      // Cast keeps the shift legal for WIDTH=1 (no zero-width replication).
      shadow_d        = (shadow_q << 1) | WIDTH'(din);
      cfg_out_d       = shadow_q[WIDTH-1];
      cfg_out_valid_d = 1'b1;
    end else begin
      cfg_out_valid_d = 1'b0;
    end
  end

  // Shadow and chain-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q        <= '0;
      cfg_out_q       <= 1'b0;
      cfg_out_valid_q <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      cfg_out_q       <= cfg_out_d;
      cfg_out_valid_q <= cfg_out_valid_d;
    end
  end

  assign shadow        = shadow_q;
  assign cfg_out       = cfg_out_q;
  assign cfg_out_valid = cfg_out_valid_q;

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: shifts WIDTH bits into a shadow register and
// commits them to the select bus c in a single step, so c never shows a
// partially loaded word.
module config_loader
  import config_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH_DEFAULT,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_out,
  output logic             cfg_out_valid,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  cfg_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic [WIDTH-1:0] shadow_s;

  cfg_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk           (clk),
    .rst           (rst),
    .shift_en      (accept_s),
    .din           (cfg_in),
    .shadow        (shadow_s),
    .cfg_out       (cfg_out),
    .cfg_out_valid (cfg_out_valid)
  );

  // Next-state, bit counter and commit logic; status flags follow the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A restart wins over a coincident bit: that bit is dropped.
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          accept_s = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = FULL_CNT;
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_COMMIT: begin
        c_d     = shadow_s;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (cfg_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_SHIFT);
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_COMMIT);
    done_d  = (state_d == ST_DONE);
  end

  // State, counter, committed word and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready = ready_q;
  assign c         = c_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader at WIDTH=8: stimulus pushes expected
// chain bits and committed words; a negedge monitor pops and compares.
module tb_config_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic         cfg_in = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic         cfg_out;
  logic         cfg_out_valid;
  logic [W-1:0] c;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic         exp_out_q[$];
  logic [W-1:0] exp_c_q[$];
  logic [W-1:0] model_sh = '0;
  logic [W-1:0] obs_out = '0;
  int           obs_cnt = 0;
  logic         done_prev = 1'b0;

  config_loader #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_in        (cfg_in),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_out       (cfg_out),
    .cfg_out_valid (cfg_out_valid),
    .c             (c),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every chain bit and every committed word against the queues.
  always @(negedge clk) begin
    if (cfg_out_valid === 1'b1) begin
      obs_out = {obs_out[W-2:0], cfg_out};
      obs_cnt++;
      if (exp_out_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cfg_out_unexpected: got valid bit %0b expected none", cfg_out);
      end else begin
        check("cfg_out", {31'b0, cfg_out}, {31'b0, exp_out_q.pop_front()});
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_c_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got c=%0h expected no commit", c);
      end else begin
        check("c_commit", {24'b0, c}, {24'b0, exp_c_q.pop_front()});
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c"}, {24'b0, c}, 32'd0);
    check({tag, "_cfg_out"}, {31'b0, cfg_out}, 32'd0);
    check({tag, "_cfg_out_valid"}, {31'b0, cfg_out_valid}, 32'd0);
    check({tag, "_cfg_ready"}, {31'b0, cfg_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_in    = b;
    exp_out_q.push_back(model_sh[W-1]);
    model_sh  = {model_sh[W-2:0], b};
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Basic load 1,0,1,1,0,0,1,0 -> B2, two-cycle latency
    start_load();
    check("t1_ready", {31'b0, cfg_ready}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    obs_cnt = 0;
    exp_c_q.push_back(8'hB2);
    send_word(8'hB2);
    check("t1_commit_busy", {31'b0, busy}, 32'd1);
    check("t1_commit_done", {31'b0, done}, 32'd0);
    check("t1_commit_ready", {31'b0, cfg_ready}, 32'd0);
    check("t1_commit_c", {24'b0, c}, 32'd0);
    tick();
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_busy_fall", {31'b0, busy}, 32'd0);
    check("t1_c", {24'b0, c}, 32'hB2);
    check("t1_out_count", obs_cnt, 32'd8);

    // Reload 3C from DONE: c holds B2 until the commit step
    start_load();
    exp_c_q.push_back(8'h3C);
    w = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      check("t6_c_hold", {24'b0, c}, 32'hB2);
    end
    tick();
    check("t6_c_new", {24'b0, c}, 32'h3C);

    // Preload A5, then a new load must forward 1,0,1,0,0,1,0,1
    start_load();
    exp_c_q.push_back(8'hA5);
    send_word(8'hA5);
    tick();
    tick();
    obs_cnt = 0;
    obs_out = '0;
    start_load();
    exp_c_q.push_back(8'hB2);
    send_word(8'hB2);
    tick();
    tick();
    check("t2_out_seq", {24'b0, obs_out}, 32'hA5);
    check("t2_out_count", obs_cnt, 32'd8);

    // Three-cycle valid gap after bit 4; cfg_start in COMMIT ignored
    start_load();
    exp_c_q.push_back(8'hB2);
    w = 8'hB2;
    for (int i = W - 1; i >= 4; i--) send_bit(w[i]);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t3_gap_ready", {31'b0, cfg_ready}, 32'd1);
      check("t3_gap_ov", {31'b0, cfg_out_valid}, 32'd0);
      check("t3_gap_done", {31'b0, done}, 32'd0);
    end
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_c", {24'b0, c}, 32'hB2);
    tick();
    check("t3_stay_done", {31'b0, done}, 32'd1);
    check("t3_stay_busy", {31'b0, busy}, 32'd0);

    // Restart at bit 5 with coincident valid, then FF
    start_load();
    exp_c_q.push_back(8'hFF);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_in    = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("t4_discard_ov", {31'b0, cfg_out_valid}, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd1);
    send_word(8'hFF);
    check("t4_c_hold", {24'b0, c}, 32'hB2);
    tick();
    check("t4_c", {24'b0, c}, 32'hFF);
    check("t4_done", {31'b0, done}, 32'd1);

    // Reset after bit 6 aborts the load; c stays 0 until a full new load
    start_load();
    w = 8'h9A;
    for (int i = W - 1; i >= 2; i--) send_bit(w[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_sh = '0;
    check_all_zero("t5_rst");
    start_load();
    exp_c_q.push_back(8'h6B);
    w = 8'h6B;
    for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
    check("t5_c_zero", {24'b0, c}, 32'd0);
    check("t5_not_done", {31'b0, done}, 32'd0);
    send_bit(w[0]);
    check("t5_c_zero_commit", {24'b0, c}, 32'd0);
    tick();
    check("t5_c", {24'b0, c}, 32'h6B);
    check("t5_done", {31'b0, done}, 32'd1);

    tick();
    check("out_queue_empty", exp_out_q.size(), 32'd0);
    check("c_queue_empty", exp_c_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
